// File: rtl/obuf_pkg.sv
// -----------------------------------------------------------------------------
// obuf_pkg
// Shared definitions for the column output collector (and the matching input
// column buffer): tile size / word width defaults and the collector state enum.
// -----------------------------------------------------------------------------
package obuf_pkg;

    // Tile geometry shared by both ends of a PE column so they agree on size.
    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 4;

    // Encoding 2'd3 is unused; the collector treats it as illegal and
    // recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } obuf_state_e;

endpackage : obuf_pkg

// File: rtl/obuf_col_collector_if.sv
// -----------------------------------------------------------------------------
// obuf_col_collector_if
// Indexed drain bus from the column collector to the result memory writer.
//
// Handshake: a word transfers on every rising CLK edge where OValid and OReady
// are both 1. While OValid=1 and OReady=0, OCOL and OWord hold their values.
// OValid never depends combinationally on OReady.
//
// Signals:
//   OValid  master->slave  word valid
//   OReady  slave->master  word accepted
//   OCOL    master->slave  slot index of the presented word (CW bits)
//   OWord   master->slave  presented result word (DW bits)
// Modports: master (collector side), slave (writer side).
// -----------------------------------------------------------------------------
interface obuf_col_collector_if #(
    parameter int DW = obuf_pkg::DW_DEF,
    parameter int CW = $clog2(obuf_pkg::DEPTH_DEF)
);
    logic          OValid;
    logic          OReady;
    logic [CW-1:0] OCOL;
    logic [DW-1:0] OWord;

    modport master (
        output OValid,
        output OCOL,
        output OWord,
        input  OReady
    );

    modport slave (
        input  OValid,
        input  OCOL,
        input  OWord,
        output OReady
    );
endinterface : obuf_col_collector_if

// File: rtl/obuf_slot_rf.sv
// -----------------------------------------------------------------------------
// obuf_slot_rf
// DEPTH x DW register file holding one column tile of results.
// One synchronous write port, one combinational read port.
//
// Ports:
//   CLK       clock, rising edge
//   RSTN      asynchronous active-low reset, clears every slot
//   we_i      write enable
//   waddr_i   write slot index
//   wdata_i   write data
//   raddr_i   read slot index
//   rdata_o   slot[raddr_i], combinational
// -----------------------------------------------------------------------------
module obuf_slot_rf #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          we_i,
    input  logic [CW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [CW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] slot_q [DEPTH];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (we_i) begin
            slot_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = slot_q[raddr_i];

endmodule : obuf_slot_rf

// File: rtl/obuf_col_collector.sv
// -----------------------------------------------------------------------------
// obuf_col_collector
// Sits at the bottom of one PE column. Captures DEPTH results (one per ENIn
// strobe, gaps allowed), then drains them as indexed words over the drain bus.
//
// Ports:
//   CLK          clock, rising edge
//   RSTN         asynchronous active-low reset
//   Clr          synchronous abort (returns to IDLE, clears Overflow/Done)
//   ENIn         result strobe from the last PE of the column
//   ID           result data, captured on edges where ENIn=1
//   drain        drain bus (master): OValid/OReady/OCOL/OWord
//   Busy         state != IDLE
//   Done         one-cycle pulse after the final drain handshake
//   Overflow     sticky: a strobe arrived while no slot was free
//   dbg_state_o  current FSM state
// -----------------------------------------------------------------------------
module obuf_col_collector
    import obuf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        Clr,
    input  logic                        ENIn,
    input  logic [DW-1:0]               ID,
    obuf_col_collector_if.master        drain,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Overflow,
    output obuf_state_e                 dbg_state_o
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    obuf_state_e   state_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic          done_q;
    logic          ovf_q;

    logic          in_drain;
    logic          hs;
    logic          final_hs;
    logic          slot_we;
    logic [DW-1:0] slot_rdata;

    assign in_drain = (state_q == ST_DRAIN);
    assign hs       = in_drain && drain.OReady;
    assign final_hs = hs && (rd_cnt_q == LAST);

    // A strobe lands in a slot while collecting, or into slot 0 when it
    // coincides with the final drain handshake (back-to-back tiles). wr_cnt_q
    // is 0 in IDLE and DRAIN, so it is the write address in every case.
    always_comb begin
        slot_we = 1'b0;
        if (!Clr && ENIn) begin
            unique case (state_q)
                ST_IDLE, ST_COLLECT: slot_we = 1'b1;
                ST_DRAIN:            slot_we = final_hs;
                default:             slot_we = 1'b0;
            endcase
        end
    end

    obuf_slot_rf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_slot_rf (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .we_i    (slot_we),
        .waddr_i (wr_cnt_q),
        .wdata_i (ID),
        .raddr_i (rd_cnt_q),
        .rdata_o (slot_rdata)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (Clr) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ENIn) begin
                        wr_cnt_q <= CW'(1);
                        state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (ENIn) begin
                        if (wr_cnt_q == LAST) begin
                            wr_cnt_q <= '0;
                            rd_cnt_q <= '0;
                            state_q  <= ST_DRAIN;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (final_hs) begin
                        done_q   <= 1'b1;
                        rd_cnt_q <= '0;
                        if (ENIn) begin
                            wr_cnt_q <= CW'(1);
                            state_q  <= ST_COLLECT;
                        end else begin
                            state_q  <= ST_IDLE;
                        end
                    end else begin
                        if (hs) begin
                            rd_cnt_q <= rd_cnt_q + CW'(1);
                        end
                        // No free slot: the strobe is dropped and flagged.
                        if (ENIn) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                end
            endcase
        end
    end

    assign drain.OValid = in_drain;
    assign drain.OCOL   = in_drain ? rd_cnt_q : '0;
    assign drain.OWord  = in_drain ? slot_rdata : '0;

    assign Busy        = (state_q != ST_IDLE);
    assign Done        = done_q;
    assign Overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule : obuf_col_collector

// File: tb/tb_obuf_col_collector.sv
module tb_obuf_col_collector;
    import obuf_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic          CLK;
    logic          RSTN;
    logic          Clr;
    logic          ENIn;
    logic [DW-1:0] ID;
    logic          Busy;
    logic          Done;
    logic          Overflow;
    obuf_state_e   dbg_state;

    obuf_col_collector_if #(.DW(DW), .CW(CW)) bus ();

    obuf_col_collector #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .Clr         (Clr),
        .ENIn        (ENIn),
        .ID          (ID),
        .drain       (bus),
        .Busy        (Busy),
        .Done        (Done),
        .Overflow    (Overflow),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic capture(input logic [DW-1:0] d, input int gap);
        ENIn = 1'b1;
        ID   = d;
        exp_q.push_back(d);
        tick();
        ENIn = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ovalid"}, 32'(bus.OValid), 32'd0);
        check({tag, "_ocol"},   32'(bus.OCOL),   32'd0);
        check({tag, "_oword"},  32'(bus.OWord),  32'd0);
        check({tag, "_busy"},   32'(Busy),       32'd0);
        check({tag, "_done"},   32'(Done),       32'd0);
    endtask

    // Drains one tile. rdy gives OReady per cycle (LSB first, then 1).
    // ovf_at: inject a stray strobe on the first cycle at that handshake count.
    // b2b: present a new strobe with b2b_id on the final handshake cycle.
    task automatic drain_tile(input logic [31:0] rdy, input int ovf_at,
                              input logic b2b, input logic [DW-1:0] b2b_id,
                              input int exp_cycles);
        int hs = 0;
        int cyc = 0;
        logic injected = 1'b0;
        logic r;
        while (hs < DEPTH && cyc < 64) begin
            check("dr_ovalid", 32'(bus.OValid), 32'd1);
            check("dr_ocol",   32'(bus.OCOL),   32'(hs));
            if (exp_q.size() > 0)
                check("dr_oword", 32'(bus.OWord), 32'(exp_q[0]));
            else
                check("dr_expq_empty", 32'(exp_q.size()), 32'd1);
            r = (cyc < 32) ? rdy[cyc] : 1'b1;
            bus.OReady = r;
            ENIn = 1'b0;
            if (ovf_at == hs && !injected) begin
                ENIn = 1'b1;
                ID   = 16'hDEAD;
                injected = 1'b1;
            end
            if (b2b && r && hs == DEPTH - 1) begin
                ENIn = 1'b1;
                ID   = b2b_id;
            end
            tick();
            if (r) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                hs++;
            end
            cyc++;
        end
        bus.OReady = 1'b0;
        ENIn = 1'b0;
        check("dr_handshakes", 32'(hs), 32'(DEPTH));
        check("dr_cycles", 32'(cyc), 32'(exp_cycles));
        check("dr_done", 32'(Done), 32'd1);
        check("dr_ovalid_after", 32'(bus.OValid), 32'd0);
        check("dr_busy_after", 32'(Busy), 32'(b2b));
        check("dr_state_after", 32'(dbg_state), b2b ? 32'(ST_COLLECT) : 32'(ST_IDLE));
        if (b2b) exp_q.push_back(b2b_id);
    endtask

    task automatic gap_tile(input string tag);
        capture(16'h0011, 1);
        check({tag, "_busy_collect"}, 32'(Busy), 32'd1);
        check({tag, "_ovalid_collect"}, 32'(bus.OValid), 32'd0);
        capture(16'h0022, 1);
        capture(16'h0033, 1);
        capture(16'h0044, 0);
        check({tag, "_state_drain"}, 32'(dbg_state), 32'(ST_DRAIN));
        drain_tile(32'hFFFF_FFFF, -1, 1'b0, '0, 4);
        tick();
        check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
        check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RSTN = 1'b0;
        Clr = 1'b0;
        ENIn = 1'b0;
        ID = '0;
        bus.OReady = 1'b0;
        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        RSTN = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        // Capture with gaps, free-flowing drain.
        gap_tile("gaps");

        // Backpressure: 3 stall cycles then 1,0,1,1,1.
        capture(16'h0011, 0);
        capture(16'h0022, 0);
        capture(16'h0033, 0);
        capture(16'h0044, 0);
        drain_tile(32'h0000_00E8, -1, 1'b0, '0, 8);
        tick();

        // Overflow: stray strobe while rd_cnt=1.
        capture(16'h1234, 0);
        capture(16'h5678, 0);
        capture(16'h9ABC, 0);
        capture(16'hDEF0, 0);
        drain_tile(32'hFFFF_FFFF, 1, 1'b0, '0, 4);
        check("ovf_set", 32'(Overflow), 32'd1);
        tick();

        // Back-to-back: next tile's slot 0 taken on the final handshake.
        capture(16'h00A1, 0);
        capture(16'h00A2, 0);
        capture(16'h00A3, 0);
        capture(16'h00A4, 0);
        drain_tile(32'hFFFF_FFFF, -1, 1'b1, 16'h0AAA, 4);
        check("ovf_sticky_b2b", 32'(Overflow), 32'd1);
        capture(16'h0BBB, 0);
        capture(16'h0CCC, 0);
        capture(16'h0DDD, 0);
        drain_tile(32'hFFFF_FFFF, -1, 1'b0, '0, 4);
        check("ovf_sticky_next", 32'(Overflow), 32'd1);
        tick();

        // Clr mid-collect after 2 captures.
        capture(16'h7777, 0);
        capture(16'h8888, 0);
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        exp_q.delete();
        check("clr_busy", 32'(Busy), 32'd0);
        check("clr_state", 32'(dbg_state), 32'(ST_IDLE));
        check("clr_ovf", 32'(Overflow), 32'd0);
        check("clr_done", 32'(Done), 32'd0);
        capture(16'h0101, 0);
        capture(16'h0202, 0);
        capture(16'h0303, 0);
        capture(16'h0404, 0);
        drain_tile(32'hFFFF_FFFF, -1, 1'b0, '0, 4);
        tick();

        // Reset during DRAIN at rd_cnt=2.
        capture(16'h0505, 0);
        capture(16'h0606, 0);
        capture(16'h0707, 0);
        capture(16'h0808, 0);
        bus.OReady = 1'b1;
        tick();
        tick();
        bus.OReady = 1'b0;
        check("rstd_ocol", 32'(bus.OCOL), 32'd2);
        check("rstd_oword", 32'(bus.OWord), 32'h0707);
        ENIn = 1'b1;
        ID = 16'hBEEF;
        tick();
        ENIn = 1'b0;
        check("rstd_ovf_set", 32'(Overflow), 32'd1);
        check("rstd_ocol_hold", 32'(bus.OCOL), 32'd2);
        #2;
        RSTN = 1'b0;
        #1;
        check_idle_outputs("rstd");
        check("rstd_ovf", 32'(Overflow), 32'd0);
        exp_q.delete();
        tick();
        RSTN = 1'b1;
        tick();
        check_idle_outputs("rstd_rel");
        gap_tile("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_obuf_col_collector

// File: doc/obuf_col_collector.md
Name: obuf_col_collector

Overview:
Output-side counterpart of the column input buffer in the MAC array. It sits at the bottom of one PE column and captures the DEPTH results that emerge one per enable strobe. Once all DEPTH results are held, it drains them as indexed words (OCOL/OWord) over a valid/ready handshake into the result memory writer. This mirrors the indexed load (ICOL/IWord) on the input side.

Parameters:
DW, 16, width of one column result word
DEPTH, 4, results per column tile; power of two, >= 2
CW, $clog2(DEPTH), width of slot index/counters

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  reset, asynchronous, active-low
Clr  input  1  synchronous abort; highest priority after RSTN
ENIn  input  1  result strobe from last PE of column (ENDown-style)
ID  input  DW  result data, sampled when ENIn=1
OValid  output  1  drain word valid
OReady  input  1  downstream accepts word
OCOL  output  CW  slot index of presented word
OWord  output  DW  presented result word
Busy  output  1  state != IDLE
Done  output  1  one-cycle pulse after final drain handshake
Overflow  output  1  sticky; ENIn arrived when no slot free

Behaviour:
- Reset (RSTN=0, async): state=IDLE, wr_cnt=0, rd_cnt=0, all slots=0, OValid=0, OCOL=0, OWord=0, Busy=0, Done=0, Overflow=0.
- FSM states: IDLE, COLLECT, DRAIN; state is registered.
- IDLE: ENIn=1 -> slot[0]<=ID, wr_cnt<=1, next state COLLECT.
- COLLECT: ENIn=1 -> slot[wr_cnt]<=ID, wr_cnt++. Gaps (ENIn=0) are allowed and hold everything. When the capture of slot DEPTH-1 occurs, next state is DRAIN, wr_cnt<=0 and rd_cnt<=0.
- DRAIN:
  - OValid=1, OCOL=rd_cnt, OWord=slot[rd_cnt]. These outputs are combinational from registered state and rd_cnt; no same-cycle dependence on OReady.
  - OValid&OReady -> rd_cnt++.
  - On the handshake with rd_cnt=DEPTH-1: Done=1 next cycle (one cycle only), rd_cnt<=0, next state IDLE.
  - OCOL/OWord must stay stable while OValid=1 and OReady=0.
- Outside DRAIN: OValid=0, OCOL=0, OWord=0.
- Capture latency: ID captured on the edge where ENIn=1. First OValid appears the cycle after the DEPTH-th capture edge. Minimum tile turnaround is DEPTH captures plus DEPTH drain cycles.
- Simultaneous events:
  - Final drain handshake and ENIn=1 in the same cycle: ENIn is accepted into slot[0], wr_cnt<=1, next state COLLECT (back-to-back tiles). Done still pulses.
  - ENIn=1 in DRAIN on any other cycle: data dropped, slots unchanged, Overflow<=1 (sticky).
- Clr=1: state=IDLE, counters=0, Overflow=0, Done=0 next cycle. Slot contents are don't-care. Clr overrides a concurrent ENIn or handshake.
- Reset mid-operation returns every output to its reset value immediately. No partial tile is preserved.
- Arithmetic: counters wrap modulo DEPTH; no arithmetic on data, which passes through bit-exact.
- Busy = (state != IDLE).

Decomposition:
- Shared package obuf_pkg holds:
  - the state enum (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2; 2'd3 is illegal and recovers to IDLE);
  - DEPTH/DW defaults, shared with the input-column buffer so both ends agree on tile size.
- One sub-module is natural: obuf_slot_rf, a DEPTH x DW register file with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr). The FSM and counters stay in the top.

Test Plan:
- Capture with gaps: ENIn pulses with ID=0x0011,0x0022,0x0033,0x0044, one idle cycle between each. Then OReady=1 -> OValid for 4 cycles, OCOL 0..3, OWord 0x0011..0x0044, Done pulse 1 cycle later, Busy=0.
- Backpressure: full tile loaded, OReady=0 for 3 cycles after OValid -> OCOL=0, OWord=0x0011 stable. Then toggling OReady 1,0,1,1,1 -> exactly 4 handshakes, in order.
- Overflow: ENIn=1 during DRAIN while rd_cnt=1 -> Overflow=1, drained words unchanged. Overflow stays high through the next tile and clears only on Clr.
- Back-to-back: ENIn=1 with ID=0x0AAA on the cycle of the final handshake -> Done=1, state COLLECT, and the next tile's OCOL=0 word is 0x0AAA after 3 more captures.
- Clr mid-COLLECT after 2 captures -> Busy=0 next cycle. The next 4 captures 0x0101..0x0404 drain as OCOL 0..3 with those values.
- RSTN asserted during DRAIN at rd_cnt=2 -> OValid, OCOL, OWord, Done, Overflow and Busy all 0 immediately. After release, a fresh tile behaves exactly as in the first scenario.
